uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of uart_rx. Captures each byte, with its parity-error flag, when uart_rx pulses rx_data_vld. Presents the bytes in order on a first-word-fall-through valid/ready interface to the host/bus side. Reports fill level, full/empty and a sticky overrun flag, plus an optional character-timeout interrupt.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo_if.sv | 15 +
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 111 +++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX/TX paths and their buffers.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  localparam int unsigned FRAME_BITS_MAX = 12;

  // Clock cycles per bit period.
  function automatic int unsigned clk_div(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// First-word-fall-through valid/ready stream from the RX buffer to its consumer.
interface uart_rx_fifo_if #(
  parameter int unsigned data_bits = 8
) ();
  import uart_pkg::*;

  logic [data_bits-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_parity_err, output m_valid, input m_ready);
  modport slave  (input m_data, input m_parity_err, input m_valid, output m_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and an occupancy counter.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned width = 9,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd,
  output logic [width-1:0]         rd_data,
  output logic [$clog2(depth):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [width-1:0] mem [depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full  = (level_q == LvlW'(depth));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A write while full still lands when the head leaves on the same edge.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-captured writes, FWFT output, sticky overrun.
// Optional character-timeout interrupt enabled by UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned data_bits     = 8,
  parameter int unsigned depth         = 16,
  parameter int unsigned clk_freq      = 50000000,
  parameter int unsigned baud_rate     = 19200,
  parameter int unsigned timeout_chars = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_bits-1:0]   rx_data_in,
  input  logic                   rx_data_vld,
  input  logic                   rx_parity_err,
  uart_rx_fifo_if.master         m,
  output logic [$clog2(depth):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   timeout_irq
);

  localparam int unsigned Limit = timeout_chars * 10 * clk_div(clk_freq, baud_rate);

  if (data_bits < 5 || data_bits > 9) begin : g_bad_width
    $error("data_bits out of range");
  end
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("depth must be a power of two >= 2");
  end
  if (Limit == 0) begin : g_bad_limit
    $error("timeout limit evaluates to zero");
  end

  logic                 vld_q;
  logic                 wr, pop;
  logic                 overrun_q, overrun_d;
  logic [data_bits:0]   head;

  assign wr  = rx_data_vld & ~vld_q;
  assign pop = m.m_valid & m.m_ready;

  uart_sync_fifo #(
    .width (data_bits + 1),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wr_data ({rx_parity_err, rx_data_in}),
    .rd      (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign m.m_valid      = ~empty;
  assign m.m_data       = head[data_bits-1:0];
  assign m.m_parity_err = head[data_bits];

  // Setting beats clearing so a drop coincident with a clear is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (wr & full & ~pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      vld_q     <= rx_data_vld;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(Limit) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            irq_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr | pop | empty)           cnt_d = '0;
    else if (cnt_q != CntW'(Limit)) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= (cnt_q == CntW'(Limit)) & ~empty;
    end
  end

  assign timeout_irq = irq_q;
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed steps plus a randomized phase against a queue model.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned Baud    = 100000;
  localparam int unsigned TChars  = 2;
`else
  localparam int unsigned ClkFreq = 50000000;
  localparam int unsigned Baud    = 19200;
  localparam int unsigned TChars  = 4;
`endif
  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data_in = '0;
  logic       rx_data_vld = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic [4:0] level;
  logic       full, empty, overrun, timeout_irq;
  logic       overrun_clr = 1'b0;

  uart_rx_fifo_if #(.data_bits(8)) mif ();

  uart_rx_fifo #(
    .data_bits     (8),
    .depth         (Depth),
    .clk_freq      (ClkFreq),
    .baud_rate     (Baud),
    .timeout_chars (TChars)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_in    (rx_data_in),
    .rx_data_vld   (rx_data_vld),
    .rx_parity_err (rx_parity_err),
    .m             (mif.master),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .timeout_irq   (timeout_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: ordered byte store, last strobe level, sticky drop flag.
  logic [8:0] q[$];
  bit         prev_vld = 0;
  bit         m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_valid", 32'(mif.m_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == Depth));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifndef UART_RX_FIFO_TIMEOUT_EN
    chk("timeout_irq", 32'(timeout_irq), 32'd0);
`endif
    if (q.size() != 0) begin
      chk("m_data", 32'(mif.m_data), 32'(q[0][7:0]));
      chk("m_parity_err", 32'(mif.m_parity_err), 32'(q[0][8]));
    end
  endtask

  task automatic cycle(input bit vld, input logic [7:0] d, input bit pe, input bit rdy,
                       input bit clr);
    bit wr, pop, set;
    logic [8:0] popped;
    rx_data_vld   = vld;
    rx_data_in    = d;
    rx_parity_err = pe;
    mif.m_ready   = rdy;
    overrun_clr   = clr;
    wr  = vld && !prev_vld;
    pop = rdy && (q.size() != 0);
    @(posedge clk);
    set = 0;
    if (pop) popped = q.pop_front();
    if (wr) begin
      if (q.size() < Depth) q.push_back({pe, d});
      else set = 1;
    end
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    prev_vld = vld;
    #1;
    check_all();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit pe);
    cycle(1, d, pe, 0, 0);
    cycle(0, d, pe, 0, 0);
  endtask

  task automatic pop_one();
    cycle(0, 8'h00, 0, 1, 0);
  endtask

  initial begin
    mif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Ordering and parity flags; first byte visible the edge after its strobe.
    cycle(1, 8'hA5, 0, 0, 0);
    chk("latency_valid", 32'(mif.m_valid), 32'd1);
    cycle(0, 8'h00, 0, 0, 0);
    write_byte(8'h3C, 1);
    write_byte(8'hFF, 0);
    chk("level3", 32'(level), 32'd3);
    chk("head_a5", 32'(mif.m_data), 32'hA5);
    pop_one();
    chk("head_3c", 32'({mif.m_parity_err, mif.m_data}), 32'h13C);
    pop_one();
    chk("head_ff", 32'({mif.m_parity_err, mif.m_data}), 32'h0FF);
    pop_one();
    chk("empty_after3", 32'(empty), 32'd1);

    // Held strobe writes once.
    repeat (5) cycle(1, 8'h42, 0, 0, 0);
    cycle(0, 8'h42, 0, 0, 0);
    chk("edge_level1", 32'(level), 32'd1);
    pop_one();

    // Fill, drop the 17th, clear racing a new drop, then clear alone.
    for (int i = 0; i < 17; i++) write_byte(8'(i + 8'h10), i[0]);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd16);
    chk("overrun_set", 32'(overrun), 32'd1);
    cycle(1, 8'hEE, 0, 0, 1);
    cycle(0, 8'hEE, 0, 0, 0);
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    cycle(0, 8'h00, 0, 0, 1);
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Full with simultaneous write and pop.
    chk("head_before", 32'(mif.m_data), 32'h10);
    cycle(1, 8'h77, 1, 1, 0);
    chk("full_wrpop_level", 32'(level), 32'd16);
    chk("full_wrpop_ovr", 32'(overrun), 32'd0);
    chk("head_after", 32'(mif.m_data), 32'h11);
    cycle(0, 8'h00, 0, 0, 0);
    while (q.size() > 1) pop_one();
    chk("last_is_new", 32'({mif.m_parity_err, mif.m_data}), 32'h177);
    pop_one();

`ifdef UART_RX_FIFO_TIMEOUT_EN
    cycle(1, 8'h5A, 0, 0, 0);
    repeat (199) cycle(0, 8'h5A, 0, 0, 0);
    chk("irq_early", 32'(timeout_irq), 32'd0);
    repeat (2) cycle(0, 8'h5A, 0, 0, 0);
    chk("irq_fired", 32'(timeout_irq), 32'd1);
    pop_one();
    cycle(0, 8'h00, 0, 0, 0);
    chk("irq_cleared", 32'(timeout_irq), 32'd0);
`else
    write_byte(8'h5A, 0);
    repeat (300) cycle(0, 8'h5A, 0, 0, 0);
    pop_one();
`endif

    // Asynchronous reset with data stored.
    write_byte(8'h01, 0);
    write_byte(8'h02, 1);
    write_byte(8'h03, 0);
    chk("pre_reset_level", 32'(level), 32'd3);
    rst = 1'b0;
    #1;
    q.delete();
    m_ovr = 0;
    prev_vld = 0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic: a filling phase then a draining phase.
    for (int i = 0; i < 800; i++) begin
      bit rdy;
      rdy = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), rdy,
            ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
